// File: rtl/q16_pkg.sv
// rtl/q16_pkg.sv - shared widths, Q1.15 limits, FIFO entry type and conversion helper
package q16_pkg;

    localparam int Q16_W = 32;
    localparam int Q15_W = 16;

    localparam logic signed [Q15_W-1:0] Q15_MAX = 16'sh7FFF;
    localparam logic signed [Q15_W-1:0] Q15_MIN = 16'sh8000;

    // Q1.15 limits widened to the Q16.16 word for range comparison
    localparam logic signed [Q16_W-1:0] WIDE_MAX = 32'sd32767;
    localparam logic signed [Q16_W-1:0] WIDE_MIN = -32'sd32768;

    typedef struct packed {
        logic signed [Q15_W-1:0] data;
        logic                    sat;
    } q15_entry_t;

    // Halve (floor) then clamp into Q1.15, flagging any clamp
    function automatic q15_entry_t q16_to_q15(input logic signed [Q16_W-1:0] x);
        logic signed [Q16_W-1:0] s;
        q15_entry_t              e;
        s = x >>> 1;
        if (s > WIDE_MAX) begin
            e.data = Q15_MAX;
            e.sat  = 1'b1;
        end else if (s < WIDE_MIN) begin
            e.data = Q15_MIN;
            e.sat  = 1'b1;
        end else begin
            e.data = s[Q15_W-1:0];
            e.sat  = 1'b0;
        end
        return e;
    endfunction

endpackage

// File: rtl/q16_fwft_fifo.sv
// rtl/q16_fwft_fifo.sv - first-word-fall-through FIFO with wrap-bit full/empty decode
module q16_fwft_fifo
    import q16_pkg::*;
#(
    parameter int  DEPTH = 4,
    parameter type T     = q15_entry_t
) (
    input  logic clk,
    input  logic rst_n,
    input  logic push,
    input  T     push_data,
    input  logic pop,
    output T     head,
    output logic full,
    output logic empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0] wptr;
    logic [AW:0] rptr;
    T            mem [DEPTH];
    logic        do_push;
    logic        do_pop;

    // Same index with differing wrap bits means every slot is occupied
    assign empty   = (wptr == rptr);
    assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Pointer update; reset discards anything buffered
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
        end
    end

    // Storage write; contents are left uninitialised on reset
    always_ff @(posedge clk) begin
        if (do_push) mem[wptr[AW-1:0]] <= push_data;
    end

    // Stale storage is never exposed: head reads as zero while empty
    assign head = empty ? T'('0) : mem[rptr[AW-1:0]];

endmodule

// File: rtl/q16_stream_rx.sv
// rtl/q16_stream_rx.sv - Q16.16 to Q1.15 stream converter with buffering and statistics
module q16_stream_rx
    import q16_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [Q16_W-1:0] in_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [Q15_W-1:0] out_data,
    input  logic                    clear_stats,
    output logic [CNT_W-1:0]        sample_count,
    output logic [CNT_W-1:0]        sat_count
);

    logic       running;
    logic       full;
    logic       empty;
    logic       push;
    logic       pop;
    q15_entry_t conv;
    q15_entry_t head;
    logic       unused_head_sat;

    // Holds in_ready low until the first edge after reset release
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) running <= 1'b0;
        else        running <= 1'b1;
    end

    assign in_ready        = running && !full;
    assign push            = in_valid && in_ready;
    assign out_valid       = !empty;
    assign pop             = out_valid && out_ready;
    assign conv            = q16_to_q15(in_data);
    assign out_data        = head.data;
    assign unused_head_sat = head.sat;

    q16_fwft_fifo #(
        .DEPTH (DEPTH),
        .T     (q15_entry_t)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (conv),
        .pop       (pop),
        .head      (head),
        .full      (full),
        .empty     (empty)
    );

    // Statistics: clear wins over counting, counters stick at all-ones
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sample_count <= '0;
            sat_count    <= '0;
        end else if (clear_stats) begin
            sample_count <= '0;
            sat_count    <= '0;
        end else if (push) begin
            if (sample_count != '1)
                sample_count <= sample_count + CNT_W'(1);
            if (conv.sat && (sat_count != '1))
                sat_count <= sat_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_q16_stream_rx.sv
// tb/tb_q16_stream_rx.sv - directed vector bench for q16_stream_rx
module tb_q16_stream_rx;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic        clear_stats = 1'b0;
    logic [31:0] in_data = '0;
    logic        in_ready;
    logic        out_valid;
    logic [15:0] out_data;
    logic [3:0]  sample_count;
    logic [3:0]  sat_count;

    int n_vec = 0;
    int n_miss = 0;
    int exp_samples = 0;
    int exp_sats = 0;

    typedef struct {
        logic [31:0] din;
        logic [15:0] dout;
        logic        sat;
    } vec_t;

    vec_t vecs [11];

    always #5 clk = ~clk;

    q16_stream_rx #(
        .DEPTH (4),
        .CNT_W (4)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .clear_stats  (clear_stats),
        .sample_count (sample_count),
        .sat_count    (sat_count)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_accept(input logic s);
        if (exp_samples < 15) exp_samples++;
        if (s && exp_sats < 15) exp_sats++;
    endtask

    task automatic chk_counts(input string name);
        chk({name, "_sample_count"}, 32'(sample_count), 32'(exp_samples));
        chk({name, "_sat_count"}, 32'(sat_count), 32'(exp_sats));
    endtask

    initial begin
        vecs[0]  = '{32'h00010000, 16'h7FFF, 1'b1};
        vecs[1]  = '{32'h00008000, 16'h4000, 1'b0};
        vecs[2]  = '{32'hFFFF0000, 16'h8000, 1'b0};
        vecs[3]  = '{32'h00000003, 16'h0001, 1'b0};
        vecs[4]  = '{32'h7FFFFFFF, 16'h7FFF, 1'b1};
        vecs[5]  = '{32'h80000000, 16'h8000, 1'b1};
        vecs[6]  = '{32'hFFFEFFFF, 16'h8000, 1'b1};
        vecs[7]  = '{32'h0000FFFF, 16'h7FFF, 1'b0};
        vecs[8]  = '{32'hFFFFFFFF, 16'hFFFF, 1'b0};
        vecs[9]  = '{32'h00000001, 16'h0000, 1'b0};
        vecs[10] = '{32'hFFFF0001, 16'h8000, 1'b0};

        // Reset state
        #2;
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_in_ready", 32'(in_ready), 32'h0);
        chk("rst_out_data", 32'(out_data), 32'h0);
        chk_counts("rst");
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("release_in_ready_pre_edge", 32'(in_ready), 32'h0);
        tick();
        chk("release_in_ready_post_edge", 32'(in_ready), 32'h1);

        // One saturating sample, one-cycle latency
        in_data = 32'h00010000;
        in_valid = 1'b1;
        #1;
        chk("empty_out_valid_low", 32'(out_valid), 32'h0);
        tick();
        in_valid = 1'b0;
        model_accept(1'b1);
        chk("one_out_valid", 32'(out_valid), 32'h1);
        chk("one_out_data", 32'(out_data), 32'h7FFF);
        chk_counts("one");
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("one_drained", 32'(out_valid), 32'h0);

        // Conversion table
        for (int i = 0; i < 11; i++) begin
            in_data = vecs[i].din;
            in_valid = 1'b1;
            tick();
            in_valid = 1'b0;
            model_accept(vecs[i].sat);
            chk($sformatf("vec%0d_valid", i), 32'(out_valid), 32'h1);
            chk($sformatf("vec%0d_data", i), 32'(out_data), 32'(vecs[i].dout));
            chk_counts($sformatf("vec%0d", i));
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
        end

        // Ordered delivery of three buffered samples
        clear_stats = 1'b1;
        tick();
        clear_stats = 1'b0;
        exp_samples = 0;
        exp_sats = 0;
        in_valid = 1'b1;
        in_data = 32'h00008000; tick(); model_accept(1'b0);
        in_data = 32'hFFFF0000; tick(); model_accept(1'b0);
        in_data = 32'h00000003; tick(); model_accept(1'b0);
        in_valid = 1'b0;
        out_ready = 1'b1;
        chk("ord0", 32'(out_data), 32'h4000); tick();
        chk("ord1", 32'(out_data), 32'h8000); tick();
        chk("ord2", 32'(out_data), 32'h0001); tick();
        out_ready = 1'b0;
        chk("ord_drained", 32'(out_valid), 32'h0);
        chk_counts("ord");

        // Fill to full with consumer stalled, then drain
        for (int i = 0; i < 5; i++) begin
            in_data = 32'(i + 1) * 32'h2000;
            in_valid = 1'b1;
            #1;
            chk($sformatf("fill%0d_in_ready", i), 32'(in_ready), 32'(i < 4));
            tick();
            if (i < 4) model_accept(1'b0);
        end
        in_valid = 1'b0;
        chk("full_hold_data", 32'(out_data), 32'h1000);
        out_ready = 1'b1;
        for (int j = 0; j < 4; j++) begin
            chk($sformatf("drain%0d_valid", j), 32'(out_valid), 32'h1);
            chk($sformatf("drain%0d_data", j), 32'(out_data), 32'(j + 1) * 32'h1000);
            tick();
            if (j == 0) chk("drain_in_ready_after_pop", 32'(in_ready), 32'h1);
        end
        out_ready = 1'b0;
        chk("drain_empty", 32'(out_valid), 32'h0);
        chk_counts("fill");

        // Streaming with both handshakes every cycle
        in_valid = 1'b1;
        out_ready = 1'b1;
        for (int k = 0; k < 20; k++) begin
            in_data = 32'(k) * 32'h200;
            if (k == 0) begin
                #1;
                chk("stream_start_empty", 32'(out_valid), 32'h0);
            end
            tick();
            model_accept(1'b0);
            chk($sformatf("stream%0d_valid", k), 32'(out_valid), 32'h1);
            chk($sformatf("stream%0d_data", k), 32'(out_data), 32'(k) * 32'h100);
            chk($sformatf("stream%0d_in_ready", k), 32'(in_ready), 32'h1);
        end
        in_valid = 1'b0;
        tick();
        out_ready = 1'b0;
        chk("stream_drained", 32'(out_valid), 32'h0);
        chk_counts("stream_saturated");

        // Clear coinciding with an accept
        clear_stats = 1'b1;
        in_valid = 1'b1;
        in_data = 32'h00010000;
        tick();
        clear_stats = 1'b0;
        in_valid = 1'b0;
        exp_samples = 0;
        exp_sats = 0;
        chk_counts("clear_same_edge");
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        model_accept(1'b1);
        chk_counts("after_clear");
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // Reset with buffered samples
        in_valid = 1'b1;
        in_data = 32'h00004000; tick(); model_accept(1'b0);
        in_data = 32'h00006000; tick(); model_accept(1'b0);
        in_data = 32'h00008000; tick(); model_accept(1'b0);
        in_valid = 1'b0;
        chk("pre_reset_valid", 32'(out_valid), 32'h1);
        chk_counts("pre_reset");
        #2;
        rst_n = 1'b0;
        #1;
        exp_samples = 0;
        exp_sats = 0;
        chk("midrst_out_valid", 32'(out_valid), 32'h0);
        chk("midrst_in_ready", 32'(in_ready), 32'h0);
        chk("midrst_out_data", 32'(out_data), 32'h0);
        chk_counts("midrst");
        tick();
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk($sformatf("post_rst%0d_no_stale", k), 32'(out_valid), 32'h0);
        end
        chk("post_rst_in_ready", 32'(in_ready), 32'h1);
        chk_counts("post_rst");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/q16_stream_rx.md
Q16_STREAM_RX -- requirements
Module: q16_stream_rx

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning FIFO entries (power of two, at least 2).
REQ-002 SHALL have parameter CNT_W, default 16, meaning statistics counter width.
REQ-003 SHALL have port clk, input, 1, meaning the single clock; all logic is rising-edge.
REQ-004 SHALL have port rst_n, input, 1, meaning reset, asynchronous and active-low.
REQ-005 SHALL have port in_valid, input, 1, meaning upstream sample valid.
REQ-006 SHALL have port in_ready, output, 1, meaning the block accepts a sample this cycle.
REQ-007 SHALL have port in_data, input, 32 signed, meaning a Q16.16 sample.
REQ-008 SHALL have port out_valid, output, 1, meaning a converted sample is available.
REQ-009 SHALL have port out_ready, input, 1, meaning the downstream consumer accepts.
REQ-010 SHALL have port out_data, output, 16 signed, meaning a Q1.15 sample.
REQ-011 SHALL have port clear_stats, input, 1, meaning synchronous clear of both counters.
REQ-012 SHALL have port sample_count, output, CNT_W, meaning accepted input samples.
REQ-013 SHALL have port sat_count, output, CNT_W, meaning accepted samples that saturated.

Function
REQ-014 SHALL accept an input sample on a rising edge where in_valid and in_ready are both 1.
REQ-015 SHALL deliver an output sample on a rising edge where out_valid and out_ready are both 1.
REQ-016 SHALL drive in_ready = !full combinationally, with no dependence on out_ready (no full-bypass).
REQ-017 SHALL convert each sample as: arithmetic shift right of in_data by 1 (truncate toward minus infinity), then saturate to the range -32768..32767.
REQ-018 SHALL flag a sample as saturated when the shifted value is greater than 32767 or less than -32768.
REQ-019 SHALL register the conversion result and saturate flag into the FIFO at the accept edge.
REQ-020 SHALL use a first-word-fall-through FIFO: out_data = head entry, out_valid = !empty.
REQ-021 SHALL give a latency of 1 cycle: a sample accepted at edge N has out_valid high after edge N.
REQ-022 SHALL keep out_data stable while out_valid=1 and out_ready=0.
REQ-023 SHALL perform push and pop together on one edge when both handshakes fire and FIFO is neither empty nor full; occupancy is then unchanged.
REQ-024 SHALL, on a full FIFO, hold in_ready low; a pop on that edge raises in_ready for the next cycle.
REQ-025 SHALL, on an empty FIFO with in_valid asserted, hold out_valid low in that cycle.
REQ-026 SHALL wrap read and write pointers modulo DEPTH, with full/empty decoded from one extra pointer bit.
REQ-027 SHALL increment sample_count by 1 per accepted sample.
REQ-028 SHALL increment sat_count by 1 per accepted sample whose saturate flag is set.
REQ-029 SHALL make both counters saturate at all-ones (no wrap).
REQ-030 SHALL give clear_stats priority over increment: on an edge with clear_stats=1 both counters become 0, even if a sample is accepted on that edge.
REQ-031 SHALL never drop or duplicate a sample.

Reset
REQ-032 SHALL, while rst_n=0, asynchronously clear pointers, FIFO occupancy, sample_count and sat_count, giving out_valid=0, in_ready=0, out_data=0.
REQ-033 SHALL raise in_ready on the first rising edge after rst_n deasserts.
REQ-034 SHALL, on reset mid-operation, discard all buffered samples and not deliver them after reset.
REQ-035 SHALL not reset FIFO storage contents; out_data is forced to 0 while empty.

Structure
REQ-036 SHALL place Q16.16 width (32), Q1.15 width (16), Q1.15 min/max constants and the FIFO-entry struct (data, sat flag) in the shared package q16_pkg.
REQ-037 SHALL implement the buffer as a sub-module q16_fwft_fifo, parameterised by DEPTH and entry type; conversion and counters live in q16_stream_rx.

Verification
REQ-038 SHALL verify: in_data=0x00010000 (1.0) -> out_data=0x7FFF one cycle later; sat_count=1; sample_count=1.
REQ-039 SHALL verify: in_data 0x00008000, 0xFFFF0000, 0x00000003 -> out_data 0x4000, 0x8000, 0x0001 in order; sat_count=0.
REQ-040 SHALL verify: out_ready=0 with 5 back-to-back inputs -> 4 accepted; in_ready low on the 5th cycle; then out_ready=1 -> 4 outputs in order; in_ready high after the first pop.
REQ-041 SHALL verify: continuous in_valid=1 and out_ready=1 for 20 samples -> one output per cycle and occupancy constant at 1.
REQ-042 SHALL verify: clear_stats=1 on the same edge as an accept -> counters=0 after that edge; the next accept -> sample_count=1.
REQ-043 SHALL verify: rst_n pulsed low with 3 buffered samples -> out_valid=0 immediately, counters=0, and no stale output after release.
